// File: rtl/button_event_arbiter.sv
// Turns debounced button levels into press/release/long-press events, shared round-robin on one
// valid/ready output. Long-press support (counters, L flags) is built only with BUTTON_EVENT_LONG_PRESS_EN.
module button_event_arbiter #(
  parameter int          NUM_BUTTONS = 4,
  parameter int          ID_WIDTH    = 2,
  parameter int          COUNT_SIZE  = 24,
  parameter int unsigned LONG_PRESS  = 24'd1200000
) (
  input  logic                   clock_in,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons_in,
  input  logic                   event_ready,
  output logic                   event_valid,
  output logic [ID_WIDTH-1:0]    event_id,
  output logic [1:0]             event_type,
  output logic [NUM_BUTTONS-1:0] pending_out,
  output logic                   overrun_out
);

  localparam logic [1:0]          TYPE_PRESS   = 2'b00;
  localparam logic [1:0]          TYPE_RELEASE = 2'b01;
  localparam logic [1:0]          TYPE_LONG    = 2'b10;
  localparam logic [ID_WIDTH-1:0] LAST_ID      = ID_WIDTH'(NUM_BUTTONS - 1);

  logic [NUM_BUTTONS-1:0] prev_q, prev_d;
  logic [NUM_BUTTONS-1:0] press_q, press_d;
  logic [NUM_BUTTONS-1:0] rel_q, rel_d;
  logic [NUM_BUTTONS-1:0] rise, fall;
  logic [NUM_BUTTONS-1:0] clr_press, clr_long, clr_rel;
  logic [NUM_BUTTONS-1:0] long_pend, long_fire;
  logic [NUM_BUTTONS-1:0] sel_oh;
  logic                   valid_q, valid_d;
  logic [ID_WIDTH-1:0]    id_q, id_d;
  logic [1:0]             type_q, type_d;
  logic [ID_WIDTH-1:0]    rr_q, rr_d;
  logic                   ovr_q, ovr_d;
  logic                   out_free;
  logic                   found;
  logic [ID_WIDTH-1:0]    sel_id;
  logic [1:0]             sel_type;

  assign rise = buttons_in & ~prev_q;
  assign fall = ~buttons_in & prev_q;

  // Round-robin search starting at rr; within one button press beats long beats release.
  always_comb begin
    int idx;
    found    = 1'b0;
    sel_id   = '0;
    sel_type = TYPE_PRESS;
    sel_oh   = '0;
    idx      = 0;
    for (int off = 0; off < NUM_BUTTONS; off++) begin
      idx = int'(rr_q) + off;
      if (idx >= NUM_BUTTONS) idx = idx - NUM_BUTTONS;
      if (!found && (press_q[idx] || long_pend[idx] || rel_q[idx])) begin
        found       = 1'b1;
        sel_id      = ID_WIDTH'(idx);
        sel_oh[idx] = 1'b1;
        if (press_q[idx])        sel_type = TYPE_PRESS;
        else if (long_pend[idx]) sel_type = TYPE_LONG;
        else                     sel_type = TYPE_RELEASE;
      end
    end
  end

  always_comb begin
    out_free  = !valid_q || event_ready;
    valid_d   = valid_q;
    id_d      = id_q;
    type_d    = type_q;
    rr_d      = rr_q;
    clr_press = '0;
    clr_long  = '0;
    clr_rel   = '0;
    if (out_free) begin
      valid_d = found;
      if (found) begin
        id_d   = sel_id;
        type_d = sel_type;
        rr_d   = (sel_id == LAST_ID) ? '0 : sel_id + ID_WIDTH'(1);
        case (sel_type)
          TYPE_PRESS: clr_press = sel_oh;
          TYPE_LONG:  clr_long  = sel_oh;
          default:    clr_rel   = sel_oh;
        endcase
      end
    end
  end

  // A new event beats a same-cycle clear; it only overruns a flag that stays pending.
  always_comb begin
    prev_d  = buttons_in;
    press_d = rise | (press_q & ~clr_press);
    rel_d   = fall | (rel_q & ~clr_rel);
    ovr_d   = ovr_q
            | (|(rise & press_q & ~clr_press))
            | (|(fall & rel_q & ~clr_rel))
            | (|(long_fire & long_pend & ~clr_long));
  end

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      prev_q  <= '0;
      press_q <= '0;
      rel_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      type_q  <= TYPE_PRESS;
      rr_q    <= '0;
      ovr_q   <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      type_q  <= type_d;
      rr_q    <= rr_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef BUTTON_EVENT_LONG_PRESS_EN
  localparam logic [COUNT_SIZE-1:0] LONG_LAST = COUNT_SIZE'(LONG_PRESS - 1);

  logic [NUM_BUTTONS-1:0][COUNT_SIZE-1:0] cnt_q, cnt_d;
  logic [NUM_BUTTONS-1:0]                 long_q, long_d;
  logic [NUM_BUTTONS-1:0]                 done_q, done_d;

  // Counter parks at LONG_LAST once the long event has fired, until the next edge.
  always_comb begin
    cnt_d     = cnt_q;
    done_d    = done_q;
    long_fire = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (rise[i] || fall[i]) begin
        cnt_d[i]  = '0;
        done_d[i] = 1'b0;
      end else if (prev_q[i] && buttons_in[i] && !done_q[i]) begin
        if (cnt_q[i] == LONG_LAST) begin
          long_fire[i] = 1'b1;
          done_d[i]    = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + COUNT_SIZE'(1);
        end
      end
    end
    long_d = long_fire | (long_q & ~clr_long);
  end

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      long_q <= '0;
      done_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      long_q <= long_d;
      done_q <= done_d;
    end
  end

  assign long_pend = long_q;
`else
  logic unused_long_cfg;

  assign long_pend       = '0;
  assign long_fire       = '0;
  assign unused_long_cfg = ^{clr_long, COUNT_SIZE[0], LONG_PRESS[0]};
`endif

  assign event_valid = valid_q;
  assign event_id    = id_q;
  assign event_type  = type_q;
  assign pending_out = press_q | long_pend | rel_q;
  assign overrun_out = ovr_q;

endmodule
